// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pic_pkg
//  Description : Shared types and helpers for the PIC priority controller:
//                channel-index width function, acknowledge FSM states and
//                EOI command encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package pic_pkg;

    // Channel-index width for an N-channel controller (at least one bit)
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Two-pulse INTA acknowledge handshake
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK2 = 1'b1
    } pic_state_t;

    // Decoded EOI command
    localparam logic [1:0] c_eoi_none    = 2'd0;
    localparam logic [1:0] c_eoi_nonspec = 2'd1;
    localparam logic [1:0] c_eoi_spec    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pic_rot_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : pic_rot_prio_enc
//  Description : Combinational rotated priority encoder. Channel
//                (lowest_ptr+1) mod N is the highest priority, wrapping
//                round to lowest_ptr as the lowest.
//  Revision    : 1.0 - initial release
// ============================================================================
module pic_rot_prio_enc #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    vec,
    input  logic [ID_W-1:0] lowest_ptr,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    logic [ID_W-1:0] w_start;
    logic [2*N-1:0]  w_dbl;
    logic [N-1:0]    w_rot;
    logic [ID_W-1:0] w_ofs;

    // Rotate so that bit 0 of w_rot is the highest-priority channel
    assign w_start = lowest_ptr + ID_W'(1);
    assign w_dbl   = {vec, vec};
    assign w_rot   = w_dbl[w_start +: N];

    // Find the lowest set bit of the rotated vector and map it back to a channel
    always_comb begin
        w_ofs = '0;
        valid = |w_rot;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_ofs = ID_W'(k);
            end
        end
        id = w_start + w_ofs;
    end

endmodule
`default_nettype wire

// File: rtl/pic_priority_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pic_priority_controller
//  Description : Clocked PIC core. Owns IRR/ISR, resolves fully-nested or
//                rotating priority, runs the two-pulse INTA handshake and
//                handles non-specific, specific and automatic EOI plus
//                set-lowest-priority rotation.
//  Revision    : 1.0 - initial release
// ============================================================================
module pic_priority_controller
    import pic_pkg::*;
#(
    parameter int N     = 8,
    parameter int ID_W  = id_width(N),
    parameter int VEC_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          irq,
    input  logic [N-1:0]          imr,
    input  logic                  level_mode,
    input  logic                  rotate_mode,
    input  logic                  auto_eoi,
    input  logic                  inta,
    input  logic                  eoi,
    input  logic                  eoi_specific,
    input  logic [ID_W-1:0]       eoi_level,
    input  logic                  set_lowest,
    input  logic [ID_W-1:0]       set_level,
    input  logic [VEC_W-ID_W-1:0] vec_base,
    output logic                  int_req,
    output logic                  vector_valid,
    output logic [VEC_W-1:0]      vector,
    output logic [N-1:0]          irr_out,
    output logic [N-1:0]          isr_out,
    output logic                  ack_busy
);

    localparam logic [N-1:0]    c_one     = N'(1);
    localparam logic [ID_W-1:0] c_spur_id = ID_W'(N - 1);

    logic [N-1:0]    r_irq_q;
    logic [N-1:0]    r_irr;
    logic [N-1:0]    r_isr;
    logic [ID_W-1:0] r_lowest_ptr;
    pic_state_t      r_state;
    logic [ID_W-1:0] r_sel;
    logic            r_spurious;
    logic            r_int_req;
    logic            r_vector_valid;
    logic [VEC_W-1:0] r_vector;

    logic [N-1:0]    w_req;
    logic            w_req_valid;
    logic [ID_W-1:0] w_req_id;
    logic            w_isr_valid;
    logic [ID_W-1:0] w_isr_id;
    logic [ID_W-1:0] w_req_rank;
    logic [ID_W-1:0] w_isr_rank;
    logic            w_cand;
    logic            w_grant;
    logic            w_auto_clr;
    logic [1:0]      w_eoi_cmd;
    logic            w_eoi_hit;
    logic [ID_W-1:0] w_eoi_id;
    logic [N-1:0]    w_set_mask;
    logic [N-1:0]    w_clr_mask;
    logic [N-1:0]    w_irr_next;
    logic [ID_W-1:0] w_ptr_next;

    assign w_req = r_irr & ~imr;

    pic_rot_prio_enc #(.N(N), .ID_W(ID_W)) u_irr_enc (
        .vec        (w_req),
        .lowest_ptr (r_lowest_ptr),
        .valid      (w_req_valid),
        .id         (w_req_id)
    );

    pic_rot_prio_enc #(.N(N), .ID_W(ID_W)) u_isr_enc (
        .vec        (r_isr),
        .lowest_ptr (r_lowest_ptr),
        .valid      (w_isr_valid),
        .id         (w_isr_id)
    );

    // Rank 0 is the highest priority; a request must strictly outrank the ISR
    assign w_req_rank = w_req_id - r_lowest_ptr - ID_W'(1);
    assign w_isr_rank = w_isr_id - r_lowest_ptr - ID_W'(1);
    assign w_cand     = w_req_valid && (!w_isr_valid || (w_req_rank < w_isr_rank));

    assign w_grant    = (r_state == IDLE) && inta && w_cand;
    assign w_auto_clr = (r_state == ACK2) && inta && auto_eoi && !r_spurious;
    assign w_eoi_cmd  = !eoi ? c_eoi_none : (eoi_specific ? c_eoi_spec : c_eoi_nonspec);

    // Resolve which ISR bit an EOI command targets; an empty ISR ignores EOI
    always_comb begin
        w_eoi_hit = 1'b0;
        w_eoi_id  = '0;
        case (w_eoi_cmd)
            c_eoi_none: begin
                w_eoi_hit = 1'b0;
            end
            c_eoi_nonspec: begin
                w_eoi_hit = w_isr_valid;
                w_eoi_id  = w_isr_id;
            end
            c_eoi_spec: begin
                w_eoi_hit = |r_isr;
                w_eoi_id  = eoi_level;
            end
            default: begin
                w_eoi_hit = 1'b0;
            end
        endcase
    end

    // Set/clear masks and next-state for IRR and the lowest-priority pointer
    always_comb begin
        w_set_mask = w_grant ? (c_one << w_req_id) : '0;
        w_clr_mask = (w_eoi_hit ? (c_one << w_eoi_id) : '0)
                   | (w_auto_clr ? (c_one << r_sel) : '0);
        if (level_mode) begin
            w_irr_next = irq;
        end else begin
            // Grant clear beats a coincident new edge on the same bit
            w_irr_next = ((r_irr | (irq & ~r_irq_q)) & irq) & ~w_set_mask;
        end
        // set_lowest beats any rotation; EOI rotation beats auto-EOI rotation
        w_ptr_next = r_lowest_ptr;
        if (set_lowest) begin
            w_ptr_next = set_level;
        end else if (rotate_mode && w_eoi_hit) begin
            w_ptr_next = w_eoi_id;
        end else if (rotate_mode && w_auto_clr) begin
            w_ptr_next = r_sel;
        end
    end

    // Request/service registers; a set of an ISR bit wins over its clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq_q      <= '0;
            r_irr        <= '0;
            r_isr        <= '0;
            r_lowest_ptr <= c_spur_id;
            r_int_req    <= 1'b0;
        end else begin
            r_irq_q      <= irq;
            r_irr        <= w_irr_next;
            r_isr        <= (r_isr & ~w_clr_mask) | w_set_mask;
            r_lowest_ptr <= w_ptr_next;
            r_int_req    <= w_cand && (r_state == IDLE);
        end
    end

    // Two-pulse INTA handshake with registered vector outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_sel          <= '0;
            r_spurious     <= 1'b0;
            r_vector_valid <= 1'b0;
            r_vector       <= '0;
        end else begin
            r_vector_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (inta) begin
                        r_state <= ACK2;
                        if (w_cand) begin
                            r_sel      <= w_req_id;
                            r_spurious <= 1'b0;
                        end else begin
                            r_sel      <= c_spur_id;
                            r_spurious <= 1'b1;
                        end
                    end
                end
                ACK2: begin
                    if (inta) begin
                        r_state        <= IDLE;
                        r_vector_valid <= 1'b1;
                        r_vector       <= {vec_base, r_sel};
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign int_req      = r_int_req;
    assign vector_valid = r_vector_valid;
    assign vector       = r_vector;
    assign irr_out      = r_irr;
    assign isr_out      = r_isr;
    assign ack_busy     = (r_state == ACK2);

endmodule
`default_nettype wire
